// File: rtl/mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// mem_resp_ctrl
//
// Word-addressed store with a fixed-latency read response and a one-cycle
// write acknowledge. It accepts one request at a time, only in IDLE. While a
// request is in progress, new requests are silently dropped.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the store (power of 2, >= 4)
//   RD_LAT       cycles from read acceptance to rvalid (1..7)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   Mem_En       request strobe
//   Mem_Read_En  read qualifier (a read only when MemWrite=0)
//   MemWrite     write qualifier (takes priority over Mem_Read_En)
//   Adr          byte address; word index = Adr[log2(DEPTH_WORDS)+1:2]
//   WriteData    write word
//   ReadData     registered read word, held until the next read completes
//   rvalid       one-cycle pulse, ReadData valid for the completed read
//   wack         one-cycle pulse, write committed (or rejected, with err)
//   busy         high while a request is in progress
//   err          one-cycle pulse, misaligned or out-of-range request
// -----------------------------------------------------------------------------
module mem_resp_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned RD_LAT      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Mem_En,
   input  logic        Mem_Read_En,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        rvalid,
   output logic        wack,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  CNT_INIT = 3'(RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_DONE = 2'd2,
      WR_ACK  = 2'd3
   } state_t;

   state_t          state_q;
   logic [2:0]      cnt_q;
   logic [AW-1:0]   idx_q;
   logic            rd_bad_q;
   logic [31:0]     rdata_q;
   logic            rvalid_q;
   logic            wack_q;
   logic            busy_q;
   logic            err_q;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [AW-1:0]   adr_idx;
   logic            adr_bad;
   logic            wr_req;
   logic            rd_req;
   logic            wr_commit;

   // Request decode. A write wins over a read when both qualifiers are set.
   assign adr_idx = Adr[AW+1:2];
   assign adr_bad = (Adr[1:0] != 2'b00) || (Adr[31:AW+2] != '0);
   assign wr_req  = Mem_En && MemWrite;
   assign rd_req  = Mem_En && Mem_Read_En && !MemWrite;

   // The store has no reset, so its enable is qualified with rst_n directly:
   // a write presented while reset is held must not land.
   assign wr_commit = rst_n && (state_q == IDLE) && wr_req && !adr_bad;

   // NOTE: storage arrays are deliberately left out of the reset domain; a
   // reset on every word would turn the array into flops and is not needed,
   // because contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem_q[adr_idx] <= WriteData;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         idx_q    <= '0;
         rd_bad_q <= 1'b0;
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         wack_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Pulse outputs default low; each is raised only for the single
         // cycle of the state that owns it.
         rvalid_q <= 1'b0;
         wack_q   <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_req) begin
                  state_q <= WR_ACK;
                  busy_q  <= 1'b1;
                  wack_q  <= 1'b1;
                  err_q   <= adr_bad;
               end else if (rd_req) begin
                  state_q  <= RD_WAIT;
                  busy_q   <= 1'b1;
                  cnt_q    <= CNT_INIT;
                  idx_q    <= adr_idx;
                  rd_bad_q <= adr_bad;
               end
            end
            RD_WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q  <= RD_DONE;
                  rvalid_q <= 1'b1;
                  err_q    <= rd_bad_q;
                  rdata_q  <= rd_bad_q ? 32'd0 : mem_q[idx_q];
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            RD_DONE, WR_ACK: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ReadData = rdata_q;
   assign rvalid   = rvalid_q;
   assign wack     = wack_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule
